clk_div_prog: RTL and testbench

//  Runtime-programmable clock divider, successor to the fixed even-ratio divider.

---
 rtl/clk_div_prog.sv | 157 +++++++++++++++
 tb/tb_clk_div_prog.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider (N = 2..2^DIV_W-1) with req/ack divisor reload.
// Define CLK_DIV_SYNC_EN to add i_sync_in, a forced period boundary used to align several dividers.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div_in,
    input  logic             i_div_load,
`ifdef CLK_DIV_SYNC_EN
    input  logic             i_sync_in,
`endif
    output logic             o_div_ack,
    output logic             o_div_err,
    output logic             o_clk_out,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_run;
    logic             r_p;
    logic             r_nq;
    logic             r_odd;
    logic             r_tick;
    logic             r_ack;
    logic             r_err;

    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] w_cnt_run;
    logic [DIV_W-1:0] w_n_next;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W:0]   w_sum;
    logic             w_wrap;
    logic             w_sync;
    logic             w_idle;
    logic             w_boundary;
    logic             w_accept;
    logic             w_bad;
    logic             w_capture;
    logic             w_apply_pend;
    logic             w_apply_now;

    // "Idle" covers stopping and the start edge: a divisor can be applied at once there.
    always_comb begin
        w_wrap       = 1'b0;
        w_cnt_nx     = '0;
        w_cnt_run    = '0;
        w_sync       = 1'b0;
        w_idle       = 1'b0;
        w_boundary   = 1'b0;
        w_accept     = 1'b0;
        w_bad        = 1'b0;
        w_capture    = 1'b0;
        w_apply_pend = 1'b0;
        w_apply_now  = 1'b0;
        w_n_next     = r_n;
        w_sum        = '0;
        w_half       = '0;

        w_wrap   = (r_cnt == (r_n - 1'b1));
        w_cnt_nx = w_wrap ? '0 : (r_cnt + 1'b1);
`ifdef CLK_DIV_SYNC_EN
        w_sync   = i_sync_in;
`else
        w_sync   = 1'b0;
`endif
        w_cnt_run    = w_sync ? '0 : w_cnt_nx;
        w_idle       = !(r_run && i_en);
        w_boundary   = r_run && i_en && (w_wrap || w_sync);
        w_accept     = i_div_load && !r_pend && !r_ack;
        w_bad        = (i_div_in < MIN_N);
        w_capture    = w_accept && !w_bad && !w_idle;
        w_apply_pend = r_pend && (w_idle || w_boundary);
        w_apply_now  = w_accept && !w_bad && w_idle;

        if (w_apply_pend) begin
            w_n_next = r_pend_div;
        end else if (w_apply_now) begin
            w_n_next = i_div_in;
        end

        // H = ceil(N/2) from the divisor in effect after this edge.
        w_sum  = {1'b0, w_n_next} + {{DIV_W{1'b0}}, 1'b1};
        w_half = w_sum[DIV_W:1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_n        <= DEF_N;
            r_pend_div <= DEF_N;
            r_pend     <= 1'b0;
            r_run      <= 1'b0;
            r_p        <= 1'b0;
            r_odd      <= DEF_N[0];
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            r_ack <= w_apply_pend || w_apply_now;
            r_n   <= w_n_next;

            if (w_apply_pend) begin
                r_pend <= 1'b0;
            end else if (w_capture) begin
                r_pend     <= 1'b1;
                r_pend_div <= i_div_in;
            end

            if (!i_en) begin
                r_cnt  <= '0;
                r_p    <= 1'b0;
                r_run  <= 1'b0;
                r_tick <= 1'b0;
                r_odd  <= w_n_next[0];
            end else if (!r_run) begin
                r_cnt  <= '0;
                r_p    <= 1'b1;
                r_run  <= 1'b1;
                r_tick <= 1'b1;
                r_odd  <= w_n_next[0];
            end else begin
                r_cnt  <= w_cnt_run;
                r_p    <= (w_cnt_run < w_half);
                r_tick <= (w_cnt_run == '0);
                // Mode only switches at a boundary, so a period is never half even, half odd.
                if (w_boundary) begin
                    r_odd <= w_n_next[0];
                end
            end
        end
    end

    // Half-cycle delayed copy of p; ANDing it in trims odd-N high time to N/2 cycles.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_nq <= 1'b0;
        end else begin
            r_nq <= r_p;
        end
    end

    assign o_clk_out = r_odd ? (r_p & r_nq) : r_p;
    assign o_tick    = r_tick;
    assign o_div_ack = r_ack;
    assign o_div_err = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: table of divisor reloads scored by period/duty measurement,
// plus hand-written reset, enable and stop-with-pending sequences.
module tb_clk_div_prog;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] divIn;
    logic             load;
    logic             ack;
    logic             err;
    logic             clkOut;
    logic             tick;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int curN = 4;

    typedef struct {
        logic [DIV_W-1:0] div;
        bit               bad;
        int               expN;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

`ifdef CLK_DIV_SYNC_EN
    logic sync = 1'b0;
    logic enA = 1'b0;
    logic enB = 1'b0;
    logic ackA, errA, clkA, tickA;
    logic ackB, errB, clkB, tickB;

    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(6)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(enA), .i_div_in(8'd0), .i_div_load(1'b0),
        .i_sync_in(sync), .o_div_ack(ackA), .o_div_err(errA), .o_clk_out(clkA), .o_tick(tickA)
    );
    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(enB), .i_div_in(8'd0), .i_div_load(1'b0),
        .i_sync_in(sync), .o_div_ack(ackB), .o_div_err(errB), .o_clk_out(clkB), .o_tick(tickB)
    );
`endif

    clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div_in   (divIn),
        .i_div_load (load),
`ifdef CLK_DIV_SYNC_EN
        .i_sync_in  (sync),
`endif
        .o_div_ack  (ack),
        .o_div_err  (err),
        .o_clk_out  (clkOut),
        .o_tick     (tick)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [DIV_W-1:0] d);
        en    = e;
        load  = l;
        divIn = d;
    endtask

    task automatic stepPos();
        @(posedge clk);
        #1;
    endtask

    task automatic stepHalf();
        @(clk);
        #1;
    endtask

    task automatic waitTick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            stepPos();
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Samples clk_out every half cycle from the current tick edge up to the next tick edge.
    task automatic measure(output int halves, output int highs, output int runts, output int acks);
        bit   fell;
        logic prev;
        fell   = 1'b0;
        prev   = clkOut;
        halves = 0;
        highs  = 0;
        runts  = 0;
        acks   = 0;
        do begin
            if (clkOut) begin
                highs++;
                if (fell) runts++;
            end
            if (prev && !clkOut) fell = 1'b1;
            prev = clkOut;
            halves++;
            stepHalf();
            if (clk && ack) acks++;
        end while (!(clk && tick) && halves < 1200);
    endtask

    task automatic checkPeriod(input string name);
        int expN, halves, highs, runts, acks;
        if (expQ.size() == 0) begin
            checkOutput({name, "_queue_empty"}, 0, 1);
            return;
        end
        expN = expQ.pop_front();
        measure(halves, highs, runts, acks);
        checkOutput({name, "_period_halfcycles"}, halves, 2 * expN);
        checkOutput({name, "_high_halfcycles"}, highs, expN);
        checkOutput({name, "_runt_pulses"}, runts, 0);
        checkOutput({name, "_stray_acks"}, acks, 0);
    endtask

    initial begin
        bit ok;
        int cycles;

        vecs[0] = '{div: 8'd5,   bad: 1'b0, expN: 5};
        vecs[1] = '{div: 8'd3,   bad: 1'b0, expN: 3};
        vecs[2] = '{div: 8'd2,   bad: 1'b0, expN: 2};
        vecs[3] = '{div: 8'd255, bad: 1'b0, expN: 255};
        vecs[4] = '{div: 8'd1,   bad: 1'b1, expN: 255};
        vecs[5] = '{div: 8'd0,   bad: 1'b1, expN: 255};
        vecs[6] = '{div: 8'd4,   bad: 1'b0, expN: 4};

        // Reset and first start with the default divisor
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (2) stepPos();
        checkOutput("reset_clk_out", int'(clkOut), 0);
        checkOutput("reset_tick", int'(tick), 0);
        checkOutput("reset_ack", int'(ack), 0);
        checkOutput("reset_err", int'(err), 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        stepPos();
        checkOutput("start_clk_out", int'(clkOut), 1);
        checkOutput("start_tick", int'(tick), 1);
        expQ.push_back(4);
        checkPeriod("default");

        // Table of reloads; each entry starts right after a tick edge
        foreach (vecs[k]) begin
            applyStimulus(1'b1, 1'b1, vecs[k].div);
            expQ.push_back(vecs[k].expN);
            if (vecs[k].bad) begin
                stepPos();
                checkOutput("err_pulse", int'(err), 1);
                checkOutput("err_no_ack", int'(ack), 0);
                applyStimulus(1'b1, 1'b0, vecs[k].div);
                stepPos();
                checkOutput("err_width", int'(err), 0);
                waitTick(ok);
                checkOutput("err_tick_timeout", int'(ok), 1);
                checkPeriod("err_unchanged");
            end else begin
                ok = 1'b0;
                cycles = 0;
                for (int i = 0; i < 600; i++) begin
                    stepPos();
                    cycles++;
                    if (ack) begin
                        ok = 1'b1;
                        break;
                    end
                end
                applyStimulus(1'b1, 1'b0, vecs[k].div);
                checkOutput("ack_seen", int'(ok), 1);
                checkOutput("ack_latency", cycles, curN);
                checkOutput("ack_at_tick", int'(tick), 1);
                checkOutput("ack_no_err", int'(err), 0);
                curN = vecs[k].expN;
                checkPeriod("reload");
            end
        end

        // Reset during the high phase with a reload pending
        applyStimulus(1'b1, 1'b1, 8'd7);
        stepPos();
        checkOutput("prereset_high", int'(clkOut), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd7);
        stepPos();
        checkOutput("rst_clk_low", int'(clkOut), 0);
        checkOutput("rst_no_ack", int'(ack), 0);
        stepPos();
        checkOutput("rst_no_ack2", int'(ack), 0);
        rst = 1'b0;
        stepPos();
        checkOutput("rst_restart_clk", int'(clkOut), 1);
        checkOutput("rst_restart_tick", int'(tick), 1);
        checkOutput("rst_restart_no_ack", int'(ack), 0);
        expQ.push_back(4);
        checkPeriod("after_reset");

        // Enable dropped mid-period, then re-raised
        stepPos();
        applyStimulus(1'b0, 1'b0, '0);
        stepPos();
        checkOutput("stop_clk_low", int'(clkOut), 0);
        checkOutput("stop_tick", int'(tick), 0);
        repeat (3) stepPos();
        checkOutput("stopped_clk_low", int'(clkOut), 0);
        applyStimulus(1'b1, 1'b0, '0);
        stepPos();
        checkOutput("restart_clk", int'(clkOut), 1);
        checkOutput("restart_tick", int'(tick), 1);
        expQ.push_back(4);
        checkPeriod("restart");

        // Enable falls while a reload is pending: applied on that stopping edge
        applyStimulus(1'b1, 1'b1, 8'd6);
        stepPos();
        checkOutput("pend_capture_no_ack", int'(ack), 0);
        applyStimulus(1'b0, 1'b1, 8'd6);
        stepPos();
        checkOutput("stop_applies_pend_ack", int'(ack), 1);
        checkOutput("stop_applies_clk_low", int'(clkOut), 0);
        applyStimulus(1'b0, 1'b0, 8'd6);
        stepPos();
        checkOutput("stop_ack_width", int'(ack), 0);
        applyStimulus(1'b1, 1'b0, 8'd6);
        stepPos();
        checkOutput("pend_restart_tick", int'(tick), 1);
        expQ.push_back(6);
        checkPeriod("stop_pend");

`ifdef CLK_DIV_SYNC_EN
        // Two dividers started out of phase, then aligned by sync_in
        enA = 1'b1;
        repeat (2) stepPos();
        enB = 1'b1;
        repeat (5) stepPos();
        sync = 1'b1;
        stepPos();
        sync = 1'b0;
        checkOutput("sync_tick_a", int'(tickA), 1);
        checkOutput("sync_tick_b", int'(tickB), 1);
        checkOutput("sync_clk_a", int'(clkA), 1);
        stepHalf();
        checkOutput("sync_clk_b_half", int'(clkB), 1);
        checkOutput("sync_clk_a_half", int'(clkA), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
